// File: rtl/fetch_unit.sv
// RV32I fetch stage: architectural PC, in-order imem requests, ring buffer of {pc, instr, filled}.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN (misaligned redirect targets become a fault entry).
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic        if_misalign
`endif
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0]      pc_q;
    logic [31:0]      ent_pc_q    [DEPTH];
    logic [31:0]      ent_instr_q [DEPTH];
    logic [DEPTH-1:0] ent_filled_q;
    logic [PW-1:0]    head_q, tail_q, fill_q;
    logic [CW-1:0]    alloc_cnt_q, unfill_cnt_q, drop_cnt_q;
    logic [CW:0]      occupancy;

    logic        accept, resp_keep, deq;
    logic        fault, fault_pend;
    logic [31:0] fault_pc;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic        fault_q, fault_pend_q;
    logic [31:0] fault_pc_q;

    // A misaligned target parks fetch and presents a single fault entry until the next redirect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault_q      <= 1'b0;
            fault_pend_q <= 1'b0;
            fault_pc_q   <= 32'h0;
        end else if (redirect_valid) begin
            fault_q      <= |redirect_pc[1:0];
            fault_pend_q <= |redirect_pc[1:0];
            fault_pc_q   <= redirect_pc;
        end else if (fault_q && if_valid && if_ready) begin
            fault_pend_q <= 1'b0;
        end
    end

    assign fault       = fault_q;
    assign fault_pend  = fault_pend_q;
    assign fault_pc    = fault_pc_q;
    assign if_misalign = fault_q && fault_pend_q;
`else
    assign fault      = 1'b0;
    assign fault_pend = 1'b0;
    assign fault_pc   = 32'h0;
`endif

    assign occupancy      = {1'b0, alloc_cnt_q} + {1'b0, drop_cnt_q};
    assign imem_req_valid = !rst && !redirect_valid && !fault && (occupancy < (CW+1)'(DEPTH));
    assign imem_req_addr  = pc_q;

    always_comb begin
        if_instr = ent_instr_q[head_q];
        if_pc    = ent_pc_q[head_q];
        if (fault) begin
            if_instr = NOP;
            if_pc    = fault_pc;
        end
        if_valid = !redirect_valid && (fault ? fault_pend : ent_filled_q[head_q]);
    end

    assign accept    = imem_req_valid && imem_req_ready;
    assign resp_keep = imem_resp_valid && (drop_cnt_q == '0);
    assign deq       = if_valid && if_ready && !fault;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q         <= RESET_PC;
            head_q       <= '0;
            tail_q       <= '0;
            fill_q       <= '0;
            alloc_cnt_q  <= '0;
            unfill_cnt_q <= '0;
            drop_cnt_q   <= '0;
            ent_filled_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_pc_q[i]    <= 32'h0;
                ent_instr_q[i] <= 32'h0;
            end
        end else if (redirect_valid) begin
            // Everything outstanding but not yet returned becomes a response to discard.
            pc_q         <= redirect_pc & 32'hFFFF_FFFC;
            head_q       <= '0;
            tail_q       <= '0;
            fill_q       <= '0;
            alloc_cnt_q  <= '0;
            unfill_cnt_q <= '0;
            ent_filled_q <= '0;
            drop_cnt_q   <= drop_cnt_q + unfill_cnt_q - CW'(imem_resp_valid);
        end else begin
            if (accept) begin
                ent_pc_q[tail_q] <= pc_q;
                tail_q           <= tail_q + 1'b1;
                pc_q             <= pc_q + 32'd4;
            end
            if (imem_resp_valid) begin
                if (drop_cnt_q != '0) begin
                    drop_cnt_q <= drop_cnt_q - 1'b1;
                end else begin
                    ent_instr_q[fill_q]  <= imem_resp_data;
                    ent_filled_q[fill_q] <= 1'b1;
                    fill_q               <= fill_q + 1'b1;
                end
            end
            if (deq) begin
                ent_filled_q[head_q] <= 1'b0;
                head_q               <= head_q + 1'b1;
            end
            alloc_cnt_q  <= alloc_cnt_q + CW'(accept) - CW'(deq);
            unfill_cnt_q <= unfill_cnt_q + CW'(accept) - CW'(resp_keep);
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: memory model with configurable latency plus an in-order scoreboard.
module tb_fetch_unit;
    localparam logic [31:0] RPC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1'b1;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        if_valid;
    logic        if_ready = 1'b1;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        if_misalign;
`endif

    always #5 clk = ~clk;

    fetch_unit #(
        .RESET_PC (RPC),
        .DEPTH    (4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_addr   (imem_req_addr),
        .imem_req_ready  (imem_req_ready),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .if_valid        (if_valid),
        .if_ready        (if_ready),
        .if_instr        (if_instr),
        .if_pc           (if_pc)
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        .if_misalign     (if_misalign)
`endif
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        mis;
    } exp_t;

    int          errors = 0;
    int          checks = 0;
    int          delivered = 0;
    int          lat = 1;
    int          cyc = 0;
    bit          fault_m = 1'b0;
    logic [31:0] exp_addr = RPC;
    exp_t        sb[$];
    logic [31:0] mem_addr[$];
    int          mem_due[$];

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return a ^ 32'h5A5A_0F13;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Instruction memory: one in-order response per accepted request, lat cycles later.
    always @(posedge clk) begin
        #1;
        cyc++;
        if (rst) begin
            mem_addr.delete();
            mem_due.delete();
            imem_resp_valid = 1'b0;
        end else if (mem_due.size() > 0 && mem_due[0] <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mdata(mem_addr[0]);
            void'(mem_addr.pop_front());
            void'(mem_due.pop_front());
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = 32'h0;
        end
    end

    // Scoreboard: expected fetch stream modelled from the bench's own PC.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            sb.delete();
            exp_addr = RPC;
            fault_m  = 1'b0;
        end else if (redirect_valid) begin
            check("redirect_no_req", {31'b0, imem_req_valid}, 32'd0);
            check("redirect_no_xfer", {31'b0, if_valid}, 32'd0);
            sb.delete();
            exp_addr = redirect_pc & 32'hFFFF_FFFC;
`ifdef FETCH_MISALIGN_TRAP_EN
            fault_m = (redirect_pc[1:0] != 2'b00);
            if (fault_m) sb.push_back('{pc: redirect_pc, instr: 32'h13, mis: 1'b1});
`endif
        end else begin
            if (if_valid && if_ready) begin
                if (sb.size() == 0) begin
                    check("deliver_unexpected", {31'b0, if_valid}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("deliver_pc", if_pc, e.pc);
                    check("deliver_instr", if_instr, e.instr);
`ifdef FETCH_MISALIGN_TRAP_EN
                    check("deliver_mis", {31'b0, if_misalign}, {31'b0, e.mis});
`endif
                    delivered++;
                end
            end
            if (imem_req_valid && imem_req_ready) begin
                if (fault_m) check("req_in_fault", {31'b0, imem_req_valid}, 32'd0);
                check("req_addr", imem_req_addr, exp_addr);
                mem_addr.push_back(imem_req_addr);
                mem_due.push_back(cyc + lat);
                sb.push_back('{pc: exp_addr, instr: mdata(exp_addr), mis: 1'b0});
                exp_addr = exp_addr + 32'd4;
            end
        end
    end

    task automatic wait_deliver(input string tag, input logic [31:0] pc, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!if_valid && n < 20);
        check({tag, "_valid"}, {31'b0, if_valid}, 32'd1);
        check({tag, "_pc"}, if_pc, pc);
        check({tag, "_instr"}, if_instr, mdata(pc));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int          d0;
        int          n;
        logic [31:0] stall_addr;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        check("rst_req_addr", imem_req_addr, RPC);
        check("rst_if_valid", {31'b0, if_valid}, 32'd0);
        check("rst_if_instr", if_instr, 32'd0);
        check("rst_if_pc", if_pc, 32'd0);

        // Stream, L=1: request in cycle 1, first delivery in cycle 3
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("c1_req_valid", {31'b0, imem_req_valid}, 32'd1);
        check("c1_req_addr", imem_req_addr, RPC);
        @(negedge clk);
        check("c2_if_valid", {31'b0, if_valid}, 32'd0);
        @(negedge clk);
        check("c3_if_valid", {31'b0, if_valid}, 32'd1);
        check("c3_if_pc", if_pc, RPC);
        @(posedge clk); #2 d0 = delivered;
        repeat (10) @(posedge clk);
        #2 check("stream_rate", delivered - d0, 32'd10);

        // Backpressure
        @(posedge clk); #1 if_ready = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        check("bp_outstanding", sb.size(), 32'd4);
        check("bp_req_valid", {31'b0, imem_req_valid}, 32'd0);
        check("bp_if_valid", {31'b0, if_valid}, 32'd1);
        @(posedge clk); #1 if_ready = 1'b1;
        #1 d0 = delivered;
        repeat (8) @(posedge clk);
        #2 check("bp_resume_rate", delivered - d0, 32'd8);

        // Redirect with responses in flight, L=3
        lat = 3;
        repeat (10) @(posedge clk);
        #1 redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0100;
        @(posedge clk); #1 redirect_valid = 1'b0;
        wait_deliver("rd_l3", 32'h0000_0100, n);

        // Redirect coinciding with a response and a ready decode, L=1
        lat = 1;
        repeat (10) @(posedge clk);
        #1 redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0200;
        @(posedge clk); #1 redirect_valid = 1'b0;
        wait_deliver("rd_sim", 32'h0000_0200, n);
        check("rd_sim_latency", n, 32'd3);

        // Memory stall
        repeat (4) @(posedge clk);
        #1 imem_req_ready = 1'b0;
        stall_addr = exp_addr;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_addr", imem_req_addr, stall_addr);
        end
        @(posedge clk); #1 imem_req_ready = 1'b1;
        wait_deliver("stall_resume", stall_addr, n);

        // Misaligned redirect target
        repeat (4) @(posedge clk);
        #1 redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0102;
        @(posedge clk); #1 redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        @(negedge clk);
        check("mis_valid", {31'b0, if_valid}, 32'd1);
        check("mis_flag", {31'b0, if_misalign}, 32'd1);
        check("mis_pc", if_pc, 32'h0000_0102);
        check("mis_instr", if_instr, 32'h0000_0013);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("mis_no_req", {31'b0, imem_req_valid}, 32'd0);
        end
        @(posedge clk); #1 redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0300;
        @(posedge clk); #1 redirect_valid = 1'b0;
        wait_deliver("mis_clear", 32'h0000_0300, n);
`else
        wait_deliver("mis_masked", 32'h0000_0100, n);
`endif

        // Reset mid-operation
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("rst2_req_valid", {31'b0, imem_req_valid}, 32'd0);
        check("rst2_req_addr", imem_req_addr, RPC);
        check("rst2_if_valid", {31'b0, if_valid}, 32'd0);
        @(posedge clk);
        @(posedge clk); #1 rst = 1'b0;
        wait_deliver("rst2_restart", RPC, n);
        check("rst2_latency", n, 32'd3);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
